// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type and bus-level constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } tgt_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: two-flop synchronizer, stability filter and edge pulses
// for one open-drain bus line. Everything idles high like a released line.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic       prev_q;

  // Bring the asynchronous bus line into the clk domain
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], line};
  end

  // Only accept a new level once it has held for FILTER_LEN samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filtered <= 1'b1;
      cnt_q    <= '0;
    end else if (sync_q[1] == filtered) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      filtered <= sync_q[1];
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Delayed copy of the filtered level used to form one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= filtered;
  end

  assign rise = filtered & ~prev_q;
  assign fall = ~filtered & prev_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C responder. Master writes leave on m_axis,
// master reads are served from s_axis. Define I2C_TARGET_CLK_STRETCH_EN to
// hold SCL low on a full write slot or an empty read source instead of
// NACKing / sending 0xFF.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda,
  input  logic       scl,
  output logic       sda_o,
  output logic       scl_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tuser,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy,
  output logic       overflow,
  output logic       underflow
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_det, stop_det;

  tgt_state_e state_q, state_n;
  logic [3:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] shift_q, shift_n, tx_q, tx_n;
  logic       rw_q, rw_n, phase_q, phase_n, stall_q, stall_n;
  logic       sda_q, sda_n, scl_q, scl_n, busy_q, busy_n, first_q, first_n;
  logic [7:0] m_tdata_q, m_tdata_n;
  logic       m_tvalid_q, m_tvalid_n, m_tuser_q, m_tuser_n;
  logic       ovf_q, ovf_n, udf_q, udf_n;
  logic       wr_load, rd_req, rd_go;
  logic [7:0] rd_byte;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .rst(rst), .line(scl),
    .filtered(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .rst(rst), .line(sda),
    .filtered(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  // Register all FSM and datapath state; drive decisions take effect one clk after the SCL edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '1;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      stall_q    <= 1'b0;
      sda_q      <= 1'b1;
      scl_q      <= 1'b1;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      tx_q       <= tx_n;
      rw_q       <= rw_n;
      phase_q    <= phase_n;
      stall_q    <= stall_n;
      sda_q      <= sda_n;
      scl_q      <= scl_n;
      busy_q     <= busy_n;
      first_q    <= first_n;
      m_tdata_q  <= m_tdata_n;
      m_tvalid_q <= m_tvalid_n;
      m_tuser_q  <= m_tuser_n;
      ovf_q      <= ovf_n;
      udf_q      <= udf_n;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise walk the byte/ACK protocol
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    tx_n       = tx_q;
    rw_n       = rw_q;
    phase_n    = phase_q;
    stall_n    = stall_q;
    sda_n      = sda_q;
    scl_n      = scl_q;
    busy_n     = busy_q;
    first_n    = first_q;
    m_tdata_n  = m_tdata_q;
    m_tvalid_n = m_tvalid_q;
    m_tuser_n  = m_tuser_q;
    ovf_n      = 1'b0;
    udf_n      = 1'b0;
    wr_load    = 1'b0;
    rd_req     = 1'b0;
    rd_go      = 1'b0;
    rd_byte    = 8'hFF;

    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_n = 1'b0;
      m_tuser_n  = 1'b0;
    end

    if (stop_det) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      scl_n   = 1'b1;
      busy_n  = 1'b0;
      phase_n = 1'b0;
      stall_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
      scl_n     = 1'b1;
      phase_n   = 1'b0;
      stall_n   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_n = {shift_q[6:0], sda_f};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_n = '0;
            if (shift_q[6:0] == TARGET_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              first_n = 1'b1;
              rw_n    = sda_f;
              phase_n = 1'b0;
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end else begin
            bit_cnt_n = bit_cnt_q + 4'd1;
          end
        end
        ADDR_ACK: begin
          if (stall_q) begin
            rd_req = 1'b1;
          end else if (scl_fall) begin
            if (!phase_q) begin
              sda_n   = ACK;
              phase_n = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              rd_req = 1'b1;
            end else begin
              sda_n   = 1'b1;
              phase_n = 1'b0;
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_n = {shift_q[6:0], sda_f};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_n = '0;
            phase_n   = 1'b0;
            state_n   = WR_ACK;
          end else begin
            bit_cnt_n = bit_cnt_q + 4'd1;
          end
        end
        WR_ACK: begin
          if (stall_q) begin
            wr_load = ~m_tvalid_q;
          end else if (scl_fall) begin
            if (phase_q) begin
              sda_n   = 1'b1;
              phase_n = 1'b0;
              state_n = WR_DATA;
            end else if (!m_tvalid_q) begin
              wr_load = 1'b1;
            end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
              stall_n = 1'b1;
              scl_n   = 1'b0;
`else
              ovf_n   = 1'b1;
              phase_n = 1'b1;
`endif
            end
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_n     = 1'b1;
            bit_cnt_n = '0;
            phase_n   = 1'b0;
            state_n   = RD_ACK;
          end else begin
            sda_n     = tx_q[7];
            tx_n      = {tx_q[6:0], 1'b1};
            bit_cnt_n = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: begin
          if (stall_q) begin
            rd_req = 1'b1;
          end else if (scl_rise && !phase_q) begin
            if (sda_f == NACK) state_n = IGNORE;
            else               phase_n = 1'b1;
          end else if (scl_fall && phase_q) begin
            rd_req = 1'b1;
          end
        end
        default: ;
      endcase

      if (wr_load) begin
        m_tdata_n  = shift_q;
        m_tvalid_n = 1'b1;
        m_tuser_n  = first_q;
        first_n    = 1'b0;
        sda_n      = ACK;
        phase_n    = 1'b1;
        stall_n    = 1'b0;
        scl_n      = 1'b1;
      end

      if (rd_req) begin
        if (s_axis_tvalid) begin
          rd_byte = s_axis_tdata;
          rd_go   = 1'b1;
        end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
          stall_n = 1'b1;
          scl_n   = 1'b0;
`else
          udf_n   = 1'b1;
          rd_go   = 1'b1;
`endif
        end
        if (rd_go) begin
          sda_n     = rd_byte[7];
          tx_n      = {rd_byte[6:0], 1'b1};
          bit_cnt_n = 4'd1;
          phase_n   = 1'b0;
          stall_n   = 1'b0;
          scl_n     = 1'b1;
          state_n   = RD_DATA;
        end
      end
    end
  end

  assign s_axis_tready = rd_req & s_axis_tvalid & ~rst;
  assign sda_o         = sda_q;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign scl_o         = scl_q;
`else
  assign scl_o         = 1'b1;
`endif
  assign busy          = busy_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tuser  = m_tuser_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule
